// File: rtl/serial_101_word_packer.sv
// -----------------------------------------------------------------------------
// serial_101_word_packer
//
// Serial-to-parallel front end for the 32-bit "101" pattern counter.
// Incoming bits are shifted into an assembly register, and the first bit of a
// word ends up at word_out[31]. A word is complete after 32 bits, or earlier
// when flush closes a partial word. A short word is left-aligned, its unused
// LSBs are zero, and word_len reports how many bits are real.
//
// The assembly register and a one-word output register give one word of
// slack. If a completed word cannot move to the output register, the packer
// enters HOLD and stops taking bits until the output drains.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bit_in       serial data bit
//   bit_valid    bit_in is valid this cycle
//   bit_ready    packer accepts a bit this cycle (depends only on state)
//   overlap_in   counting mode, latched with the first bit of a word
//   flush        close the current partial word (ignored when it is empty)
//   word_out     assembled word, first received bit at [31]
//   word_len     number of real bits in word_out, 1..32
//   overlap_out  mode latched for word_out
//   word_valid   word_out / word_len / overlap_out are valid
//   word_ready   downstream accepts the word this cycle
//   words_sent   count of transferred words, wraps at 16 bits
// -----------------------------------------------------------------------------
module serial_101_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  input  logic        overlap_in,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic [5:0]  word_len,
  output logic        overlap_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] words_sent
);

  typedef enum logic {
    FILL = 1'b0,  // collecting bits
    HOLD = 1'b1   // complete word waiting for the output register
  } state_t;

  state_t      state, state_nxt;

  // Assembly register
  logic [31:0] sreg;
  logic [5:0]  cnt;
  logic        ovl_a;

  // Per-cycle views of the assembly register, as if the bit accepted this
  // cycle were already shifted in
  logic        accept;
  logic [31:0] sreg_eff;
  logic [5:0]  cnt_eff;
  logic        ovl_eff;

  logic        drain;      // output word transfers this cycle
  logic        out_free;   // output register can take a word this cycle
  logic        complete;   // assembly closes a word this cycle (FILL only)
  logic        load;       // assembly word moves to the output register
  logic [31:0] load_word;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven from always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: if (complete && !out_free) state_nxt = HOLD;
      HOLD: if (drain)                 state_nxt = FILL;
      default:                         state_nxt = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. bit_ready comes from state alone, so it never combinationally
  // depends on bit_valid or flush.
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_ready = (state == FILL);
  end

  // ---------------------------------------------------------------------------
  // Datapath decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    accept   = bit_valid && bit_ready;
    sreg_eff = accept ? {sreg[30:0], bit_in} : sreg;
    cnt_eff  = cnt + {5'd0, accept};
    // The mode is captured by the first bit of a word only.
    ovl_eff  = (accept && (cnt == 6'd0)) ? overlap_in : ovl_a;

    drain    = word_valid && word_ready;
    out_free = !word_valid || drain;

    // A flush with nothing collected (effective count 0) is a no-op.
    complete = (state == FILL) &&
               ((cnt_eff == 6'd32) || (flush && (cnt_eff != 6'd0)));

    // In HOLD no bit is accepted, so the *_eff views equal the stored word.
    load     = (complete && out_free) || ((state == HOLD) && drain);

    // Left-align a short word; a full word shifts by zero. cnt_eff is 1..32
    // whenever load is set, so the shift amount stays within 0..31.
    load_word = sreg_eff << (6'd32 - cnt_eff);
  end

  // ---------------------------------------------------------------------------
  // Assembly register. On completion into HOLD the effective values are kept,
  // so the pending word already includes any bit accepted in that cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= '0;
      cnt   <= '0;
      ovl_a <= 1'b0;
    end else if (load) begin
      sreg  <= '0;
      cnt   <= '0;
      ovl_a <= 1'b0;
    end else if (accept) begin
      sreg  <= sreg_eff;
      cnt   <= cnt_eff;
      ovl_a <= ovl_eff;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. The fields are only written on load, so they stay stable
  // while word_valid && !word_ready. A load in the same cycle as a drain
  // replaces the departing word with no bubble on word_valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_out    <= '0;
      word_len    <= '0;
      overlap_out <= 1'b0;
      word_valid  <= 1'b0;
    end else if (load) begin
      word_out    <= load_word;
      word_len    <= cnt_eff;
      overlap_out <= ovl_eff;
      word_valid  <= 1'b1;
    end else if (drain) begin
      word_valid  <= 1'b0;
    end
  end

  // Transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_sent <= '0;
    end else if (drain) begin
      words_sent <= words_sent + 16'd1;
    end
  end

endmodule
